// File: rtl/coffee_buyer.sv
// Payment master for the coffee vending FSM: pays for N coffees coin by coin and checks each coffee response.
// Latency: first coin in the cycle after accept, then one coin every 1+GAP cycles; done in the cycle after the last coin.
// Backpressure: req_ready is high only in IDLE; req_valid is ignored otherwise, and ERROR holds until reset.
module coffee_buyer #(
    parameter int COUNT_W = 4,
    parameter int CNT_W   = 8,
    parameter int GAP     = 1
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_req_valid,
    input  logic [COUNT_W-1:0] i_req_count,
    input  logic               i_dimes_only,
    output logic               o_req_ready,
    output logic [1:0]         o_coins,
    input  logic               i_coffee,
    output logic               o_done,
    output logic               o_error,
    output logic [CNT_W-1:0]   o_nickels_spent,
    output logic [CNT_W-1:0]   o_dimes_spent
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [1:0]         COIN_NONE   = 2'b00;
    localparam logic [1:0]         COIN_NICKEL = 2'b10;
    localparam logic [1:0]         COIN_DIME   = 2'b01;
    localparam logic [3:0]         GAP_LAST    = 4'(GAP - 1);
    localparam logic [COUNT_W-1:0] REM_ONE     = COUNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);

    state_t             r_state, w_next_state;
    logic [1:0]         r_credit, w_credit_nxt;   // mirror of machine credit, in units of 5 cents
    logic [COUNT_W-1:0] r_remaining, w_remaining_nxt;
    logic               r_dimes_only;
    logic [3:0]         r_gap_cnt;
    logic [CNT_W-1:0]   r_nickels, r_dimes;

    logic               w_accept;
    logic               w_inc_nickel, w_inc_dime;
    logic               w_coin_is_dime;
    logic [2:0]         w_sum;
    logic               w_exp_coffee;
    logic [1:0]         w_credit_after;

    // Mixed policy tops up with a dime until credit is 10, then finishes with a nickel.
    assign w_coin_is_dime = r_dimes_only | (r_credit != 2'd2);
    assign w_sum          = {1'b0, r_credit} + (w_coin_is_dime ? 3'd2 : 3'd1);
    assign w_exp_coffee   = (w_sum >= 3'd3);
    assign w_credit_after = w_exp_coffee ? 2'(w_sum - 3'd3) : w_sum[1:0];

    always_comb begin
        w_next_state    = r_state;
        w_credit_nxt    = r_credit;
        w_remaining_nxt = r_remaining;
        w_accept        = 1'b0;
        w_inc_nickel    = 1'b0;
        w_inc_dime      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_coffee) begin
                    w_next_state = S_ERROR;
                end else if (i_req_valid) begin
                    w_accept        = 1'b1;
                    w_remaining_nxt = i_req_count;
                    w_next_state    = (i_req_count == '0) ? S_DONE : S_SEND;
                end
            end
            S_SEND: begin
                w_inc_dime   = w_coin_is_dime;
                w_inc_nickel = ~w_coin_is_dime;
                if (i_coffee == w_exp_coffee) begin
                    w_credit_nxt = w_credit_after;
                    if (w_exp_coffee) begin
                        w_remaining_nxt = r_remaining - REM_ONE;
                    end
                    w_next_state = (w_exp_coffee && r_remaining == REM_ONE) ? S_DONE : S_GAP;
                end else begin
                    w_next_state = S_ERROR;
                end
            end
            S_GAP: begin
                if (i_coffee) begin
                    w_next_state = S_ERROR;
                end else if (r_gap_cnt == GAP_LAST) begin
                    w_next_state = S_SEND;
                end
            end
            S_DONE: begin
                w_next_state = i_coffee ? S_ERROR : S_IDLE;
            end
            S_ERROR: begin
                w_next_state = S_ERROR;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= S_IDLE;
            r_credit     <= 2'd0;
            r_remaining  <= '0;
            r_dimes_only <= 1'b0;
            r_gap_cnt    <= 4'd0;
            r_nickels    <= '0;
            r_dimes      <= '0;
        end else begin
            r_state     <= w_next_state;
            r_credit    <= w_credit_nxt;
            r_remaining <= w_remaining_nxt;
            if (w_accept) begin
                r_dimes_only <= i_dimes_only;
            end
            r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + 4'd1 : 4'd0;
            if (w_inc_nickel) begin
                r_nickels <= r_nickels + CNT_ONE;
            end
            if (w_inc_dime) begin
                r_dimes <= r_dimes + CNT_ONE;
            end
        end
    end

    assign o_req_ready     = (r_state == S_IDLE);
    assign o_done          = (r_state == S_DONE);
    assign o_error         = (r_state == S_ERROR);
    assign o_coins         = (r_state != S_SEND) ? COIN_NONE :
                             (w_coin_is_dime ? COIN_DIME : COIN_NICKEL);
    assign o_nickels_spent = r_nickels;
    assign o_dimes_spent   = r_dimes;

endmodule

// File: tb/tb_coffee_buyer.sv
// Directed bench for coffee_buyer against a behavioural vending machine model.
module tb_coffee_buyer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic [3:0] req_count;
    logic       dimes_only;
    logic       req_ready;
    logic [1:0] coins;
    logic       coffee;
    logic       done;
    logic       error;
    logic [7:0] nickels;
    logic [7:0] dimes;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    coffee_buyer #(.COUNT_W(4), .CNT_W(8), .GAP(1)) dut (
        .i_clk           (clk),
        .i_reset_n       (rst_n),
        .i_req_valid     (req_valid),
        .i_req_count     (req_count),
        .i_dimes_only    (dimes_only),
        .o_req_ready     (req_ready),
        .o_coins         (coins),
        .i_coffee        (coffee),
        .o_done          (done),
        .o_error         (error),
        .o_nickels_spent (nickels),
        .o_dimes_spent   (dimes)
    );

    // Vending machine: Mealy coffee output, credit in units of 5 cents; m_kill/m_force1 inject faults.
    logic [1:0] m_credit;
    logic [2:0] m_val;
    logic [2:0] m_sum;
    logic       m_kill;
    logic       m_force1;

    always_comb begin
        m_val  = (coins == 2'b10) ? 3'd1 : (coins == 2'b01) ? 3'd2 : 3'd0;
        m_sum  = {1'b0, m_credit} + m_val;
        coffee = m_force1 | (!m_kill && m_val != 3'd0 && m_sum >= 3'd3);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            m_credit <= 2'd0;
        else if (m_val != 3'd0 && !m_kill)
            m_credit <= (m_sum >= 3'd3) ? 2'(m_sum - 3'd3) : m_sum[1:0];
    end

    task step;
        @(posedge clk);
        #1;
    endtask

    task apply_reset;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        m_kill    = 1'b0;
        m_force1  = 1'b0;
        step;
        step;
        rst_n = 1'b1;
    endtask

    task accept(input logic [3:0] n, input logic d);
        req_count  = n;
        dimes_only = d;
        req_valid  = 1'b1;
        step;
        req_valid  = 1'b0;
    endtask

    task test_reset;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (coins !== 2'b00 || req_ready !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: coins=%b ready=%b done=%b error=%b, want 00 1 0 0", coins, req_ready, done, error);
        end
        checks++;
        if (nickels !== 8'd0 || dimes !== 8'd0) begin
            errors++;
            $display("FAIL reset_counters: nickels=%0d dimes=%0d, want 0 0", nickels, dimes);
        end
        step;
        rst_n = 1'b1;
        accept(4'd3, 1'b0);
        step;
        checks++;
        if (coins !== 2'b00 || dimes !== 8'd1) begin
            errors++;
            $display("FAIL pre_reset_gap: coins=%b dimes=%0d, want 00 1", coins, dimes);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (coins !== 2'b00 || req_ready !== 1'b1 || error !== 1'b0 || dimes !== 8'd0 || nickels !== 8'd0) begin
            errors++;
            $display("FAIL midgap_reset: coins=%b ready=%b error=%b dimes=%0d nickels=%0d, want 00 1 0 0 0",
                     coins, req_ready, error, dimes, nickels);
        end
        step;
        rst_n = 1'b1;
    endtask

    task test_mixed_one;
        accept(4'd1, 1'b0);
        checks++;
        if (coins !== 2'b01 || coffee !== 1'b0) begin
            errors++;
            $display("FAIL mixed1_coin1: coins=%b coffee=%b, want 01 0", coins, coffee);
        end
        step;
        checks++;
        if (coins !== 2'b00) begin
            errors++;
            $display("FAIL mixed1_gap: coins=%b, want 00", coins);
        end
        step;
        checks++;
        if (coins !== 2'b10 || coffee !== 1'b1) begin
            errors++;
            $display("FAIL mixed1_coin2: coins=%b coffee=%b, want 10 1", coins, coffee);
        end
        step;
        checks++;
        if (done !== 1'b1 || coins !== 2'b00 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL mixed1_done: done=%b coins=%b ready=%b, want 1 00 0", done, coins, req_ready);
        end
        step;
        checks++;
        if (done !== 1'b0 || req_ready !== 1'b1 || nickels !== 8'd1 || dimes !== 8'd1 || error !== 1'b0) begin
            errors++;
            $display("FAIL mixed1_end: done=%b ready=%b nickels=%0d dimes=%0d error=%b, want 0 1 1 1 0",
                     done, req_ready, nickels, dimes, error);
        end
    endtask

    task test_credit_carry;
        apply_reset;
        accept(4'd1, 1'b1);
        checks++;
        if (coins !== 2'b01 || coffee !== 1'b0) begin
            errors++;
            $display("FAIL carry_coin1: coins=%b coffee=%b, want 01 0", coins, coffee);
        end
        step;
        step;
        checks++;
        if (coins !== 2'b01 || coffee !== 1'b1) begin
            errors++;
            $display("FAIL carry_coin2: coins=%b coffee=%b, want 01 1", coins, coffee);
        end
        step;
        step;
        accept(4'd1, 1'b0);
        checks++;
        if (coins !== 2'b01 || coffee !== 1'b1) begin
            errors++;
            $display("FAIL carry_single: coins=%b coffee=%b, want 01 1", coins, coffee);
        end
        step;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL carry_done: done=%b, want 1", done);
        end
        step;
        checks++;
        if (dimes !== 8'd3 || nickels !== 8'd0 || req_ready !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL carry_counts: dimes=%0d nickels=%0d ready=%b error=%b, want 3 0 1 0",
                     dimes, nickels, req_ready, error);
        end
    endtask

    task test_count_zero;
        accept(4'd0, 1'b0);
        checks++;
        if (done !== 1'b1 || coins !== 2'b00) begin
            errors++;
            $display("FAIL zero_done: done=%b coins=%b, want 1 00", done, coins);
        end
        step;
        checks++;
        if (done !== 1'b0 || req_ready !== 1'b1 || coins !== 2'b00 || dimes !== 8'd3 || nickels !== 8'd0) begin
            errors++;
            $display("FAIL zero_after: done=%b ready=%b coins=%b dimes=%0d nickels=%0d, want 0 1 00 3 0",
                     done, req_ready, coins, dimes, nickels);
        end
    endtask

    task test_back_to_back;
        int         n_coffee;
        int         n_done;
        logic [1:0] exp_coins;
        n_coffee = 0;
        n_done   = 0;
        accept(4'd3, 1'b0);
        for (int i = 0; i < 11; i++) begin
            exp_coins = (i % 2 == 1) ? 2'b00 : (((i / 2) % 2 == 0) ? 2'b01 : 2'b10);
            checks++;
            if (coins !== exp_coins) begin
                errors++;
                $display("FAIL b2b_coin[%0d]: coins=%b, want %b", i, coins, exp_coins);
            end
            if (coffee === 1'b1) n_coffee++;
            if (done === 1'b1) n_done++;
            step;
        end
        checks++;
        if (done !== 1'b1 || n_done != 0 || n_coffee != 3) begin
            errors++;
            $display("FAIL b2b_pulses: done=%b early_done=%0d coffee_pulses=%0d, want 1 0 3", done, n_done, n_coffee);
        end
        step;
        checks++;
        if (done !== 1'b0 || req_ready !== 1'b1 || dimes !== 8'd6 || nickels !== 8'd3 || error !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: done=%b ready=%b dimes=%0d nickels=%0d error=%b, want 0 1 6 3 0",
                     done, req_ready, dimes, nickels, error);
        end
    endtask

    task test_error;
        accept(4'd1, 1'b0);
        step;
        m_kill = 1'b1;
        step;
        checks++;
        if (coins !== 2'b10 || coffee !== 1'b0) begin
            errors++;
            $display("FAIL err_inject: coins=%b coffee=%b, want 10 0", coins, coffee);
        end
        step;
        m_kill = 1'b0;
        checks++;
        if (error !== 1'b1 || coins !== 2'b00 || req_ready !== 1'b0 || nickels !== 8'd4) begin
            errors++;
            $display("FAIL err_state: error=%b coins=%b ready=%b nickels=%0d, want 1 00 0 4",
                     error, coins, req_ready, nickels);
        end
        req_count = 4'd1;
        req_valid = 1'b1;
        repeat (3) step;
        req_valid = 1'b0;
        checks++;
        if (error !== 1'b1 || coins !== 2'b00 || req_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL err_sticky: error=%b coins=%b ready=%b done=%b, want 1 00 0 0", error, coins, req_ready, done);
        end
        apply_reset;
        checks++;
        if (error !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL err_clear: error=%b ready=%b, want 0 1", error, req_ready);
        end
    endtask

    task test_spurious_coffee;
        m_force1 = 1'b1;
        step;
        m_force1 = 1'b0;
        checks++;
        if (error !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_coffee: error=%b ready=%b, want 1 0", error, req_ready);
        end
        apply_reset;
    endtask

    initial begin
        rst_n      = 1'b1;
        req_valid  = 1'b0;
        req_count  = 4'd0;
        dimes_only = 1'b0;
        m_kill     = 1'b0;
        m_force1   = 1'b0;
        test_reset;
        test_mixed_one;
        test_credit_carry;
        test_count_zero;
        test_back_to_back;
        test_error;
        test_spurious_coffee;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/coffee_buyer.md
# coffee_buyer

Customer-side driver for the coffee vending FSM: accepts a request for N coffees and pays for them by emitting one-cycle coin codes on the machine's `coins` bus. It watches the machine's Mealy `coffee` output and checks every coin against an internal mirror of the machine's credit. It counts coins spent and sets a sticky error on any mismatch. It sits opposite the vending FSM on the same clock, as a stimulus/payment master in the practice FSM set.

## Interface
- `COUNT_W`, default 4: width of requested coffee count.
- `CNT_W`, default 8: width of coin-spent counters.
- `GAP`, default 1: idle cycles (`coins`=00) inserted between consecutive coins; legal range 1 to 15.

- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_count` input COUNT_W: number of coffees to buy.
- `dimes_only` input 1: coin policy; sampled at request accept.
- `req_ready` output 1: block idle and able to accept.
- `coins` output 2: to the machine. 00 = none, 10 = 5 cents, 01 = 10 cents. 11 is never driven.
- `coffee` input 1: from the machine; combinational response to `coins`.
- `done` output 1: one-cycle pulse when a request completes.
- `error` output 1: sticky mismatch flag.
- `nickels_spent` output CNT_W: running count of 5-cent coins.
- `dimes_spent` output CNT_W: running count of 10-cent coins.

## Operation
- States: IDLE, SEND, GAP, DONE, ERROR.
- Credit mirror holds 0, 5 or 10 cents and persists across requests. It is cleared only by reset; the system resets the machine together with this block.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`=1, latch `req_count` into a remaining-coffee counter and latch `dimes_only`.
  - If `req_count`=0, go to DONE; otherwise go to SEND.
- **SEND**
  - Drive exactly one coin for one cycle.
  - Mixed policy (`dimes_only`=0): credit 0 → dime; credit 5 → dime; credit 10 → nickel.
  - Dimes-only policy: always a dime.
  - Expected coffee and next credit:
    - 0 + dime → 10, no coffee.
    - 0 + nickel → 5, no coffee.
    - 5 + nickel → 10, no coffee.
    - 5 + dime → 0, coffee.
    - 10 + nickel → 0, coffee.
    - 10 + dime → 5, coffee.
  - In the same cycle, sample `coffee`. If it equals the expected value, update the credit mirror, increment the matching spent counter, and on coffee decrement the remaining count.
  - Then go to DONE if the remaining count reaches 0; otherwise go to GAP.
  - On mismatch, go to ERROR. The spent counter still increments; credit and remaining count do not update.
- **GAP**: `coins`=00 for GAP cycles, then return to SEND.
- **DONE**: `done`=1 for one cycle, `coins`=00, then IDLE.
- **ERROR**
  - `error`=1, `coins`=00, `req_ready`=0.
  - Exit only by reset.
- `coffee`=1 in any cycle where `coins`=00 (IDLE, GAP, DONE) also forces ERROR on the next edge.
- Spent counters wrap modulo 2^CNT_W.

## Timing
- Reset values:
  - state IDLE, credit 0.
  - `coins`=00, `done`=0, `error`=0, `req_ready`=1.
  - Both counters 0.
- Accept edge: the edge where `req_valid`=1 and `req_ready`=1. The first coin is driven in the cycle after accept.
- `coins`, `done`, `req_ready` and `error` are registered or state-decoded only, with no combinational path from inputs.
- Coin cycle spacing is 1+GAP cycles.
- `done` rises in the cycle after the final coin; `req_ready` is 1 one cycle later.
- `req_valid` is ignored while `req_ready`=0.
- Reset asserted mid-request: immediately `coins`=00, and all state and counters return to their reset values.

## Test plan
- **Reset:** assert `reset`=0 mid-GAP → `coins`=00, `req_ready`=1, counters 0, `error`=0. After release, a new request starts from credit 0.
- **Mixed, count=1, GAP=1 from credit 0:**
  - `coins` = 01, 00, 10; `coffee`=1 only on the 10 cycle.
  - `done` one cycle later.
  - Result: `nickels_spent`=1, `dimes_spent`=1.
- **Credit carry:**
  - `dimes_only`=1, count=1 → 01, 00, 01 (`coffee` on the 2nd coin); credit left at 5.
  - Then mixed, count=1 → a single 01 with `coffee`=1.
  - Result: `dimes_spent`=3, `nickels_spent`=0.
- **count=0:** `done` pulses the cycle after accept, no coins driven, counters unchanged.
- **Error injection:** the model forces `coffee`=0 on an expected-coffee coin → `error`=1 next cycle, `coins` stuck at 00, `req_ready`=0, new `req_valid` ignored until reset.
- **Back-to-back mixed, count=3:** six coins alternating 01/10 with GAP spacing, three `coffee` pulses, a single `done`, final credit 0.
